seq_alu_unit: RTL and testbench
===============================

// Module: seq_alu_unit
// PURPOSE
//  Execute-stage ALU consuming the 4-bit alu_control code from the ALU decoder plus two operands.
//  Registered output with valid/ready handshakes on both sides.
//  Shifts run iteratively (1 bit/cycle) unless the barrel-shift option is compiled in.
//  Sits between decode/operand-select and writeback.
// PARAMETERS
//  XLEN     32            operand/result width
//  SHW      $clog2(XLEN)  shift-amount width; shamt = src_b[SHW-1:0]
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     operation offered
//  in_ready     out  1     unit accepts operation this cycle
//  alu_control  in   4     0000 ADD 0001 SUB 0010 SLL 0011 SLT 0100 SLTU 0101 XOR 0110 SRL 0111 SRA 1000 OR 1001 AND
//  src_a        in   XLEN  operand A
//  src_b        in   XLEN  operand B
//  out_valid    out  1     result valid, held until out_ready
//  out_ready    in   1     consumer takes result
//  result       out  XLEN  registered result
//  zero         out  1     result == 0, registered with result
//  busy         out  1     high in SHIFT state
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): state=IDLE; out_valid=0, result=0, zero=1, busy=0; in-flight shift abandoned, no output produced.
//  - Accept: in_valid && in_ready at clk edge. Operands/code latched.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready). Same-cycle hand-off allowed: old result consumed, new op accepted.
//  - FSM states:
//    - IDLE: non-shift op, or shift with shamt==0 -> compute, load result, out_valid=1 next cycle (latency 1). Shift with shamt!=0 -> SHIFT.
//    - SHIFT: shift working reg 1 bit/cycle, decrement counter. When counter reaches 0 -> load result, out_valid=1, return to IDLE.
//    - Latency for a shift = shamt+1 cycles from accept to out_valid.
//  - out_valid falls the cycle after out_valid && out_ready unless a new op completes on that same edge.
//  - result/zero stable while out_valid && !out_ready.
//  - Arithmetic:
//    - ADD/SUB modulo 2^XLEN, no overflow flag.
//    - SLT signed compare, SLTU unsigned; result = {XLEN-1 zeros, bit}.
//    - SRA replicates src_a[XLEN-1]. Only src_b[SHW-1:0] used for shifts.
//    - Codes 1010-1111: result 0, latency 1, no error.
//  - in_valid ignored while in_ready=0; operands need not be held after accept.
//  - rst asserted in SHIFT or with out_valid pending: cleared next edge, result discarded.
// CONFIGURATION
//  - ALU_BARREL_SHIFT_EN defined: shifts computed combinationally in IDLE; every op latency 1; SHIFT state never entered, busy tied 0.
//  - Not defined: iterative shifter as above; smaller area.
// TESTING
//  1. rst=1 for 2 cycles -> out_valid=0, result=0, zero=1, in_ready=1 after release.
//  2. ADD a=32'h7FFF_FFFF b=1 -> result 32'h8000_0000 one cycle after accept. SUB a=5 b=5 -> result 0, zero=1.
//  3. SLT a=32'hFFFF_FFFF b=1 -> 1. SLTU with same operands -> 0.
//  4. SRA a=32'h8000_0000 b=31 -> 32'hFFFF_FFFF, out_valid 32 cycles after accept (iterative), 1 (BARREL). SLL shamt=0 -> latency 1.
//  5. out_ready=0 for 5 cycles after result -> result held, in_ready=0. Then out_ready=1 with in_valid=1 XOR -> hand-off same cycle, new result next cycle.
//  6. SRL with shamt=20, rst pulsed at cycle 10 -> no out_valid, state IDLE; code 4'b1111 -> result 0 after 1 cycle.

Source files
------------

// File: rtl/seq_alu_unit.sv
`default_nettype none
// ============================================================================
// Module : seq_alu_unit
// Execute-stage ALU with registered result and valid/ready handshakes.
// Shifts iterate one bit per cycle unless ALU_BARREL_SHIFT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module seq_alu_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            load;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] load_val;

  assign shamt    = src_b[SHW-1:0];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (alu_control)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
`else
      // Only the shamt==0 case completes here; nonzero shifts go iterative.
      OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign busy = 1'b0;

  always_comb begin
    state_next = IDLE;
    load       = accept;
    load_val   = alu_res;
  end
`else
  logic            start_shift;
  logic            last_step;
  logic [XLEN-1:0] sh_val;
  logic [XLEN-1:0] sh_step;
  logic [SHW-1:0]  sh_cnt;
  logic [3:0]      sh_op;

  assign start_shift = accept && (shamt != '0) &&
                       ((alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                        (alu_control == OP_SRA));
  assign busy      = (state == SHIFT);
  assign last_step = (sh_cnt == SHW'(1));

  always_comb begin
    sh_step = sh_val;
    case (sh_op)
      OP_SLL:  sh_step = {sh_val[XLEN-2:0], 1'b0};
      OP_SRL:  sh_step = {1'b0, sh_val[XLEN-1:1]};
      OP_SRA:  sh_step = {sh_val[XLEN-1], sh_val[XLEN-1:1]};
      default: sh_step = sh_val;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = alu_res;
    case (state)
      IDLE: begin
        if (start_shift) state_next = SHIFT;
        else             load       = accept;
      end
      SHIFT: begin
        // The final step's shifted value goes straight into the result.
        if (last_step) begin
          state_next = IDLE;
          load       = 1'b1;
          load_val   = sh_step;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val <= '0;
      sh_cnt <= '0;
      sh_op  <= OP_SLL;
    end else if (start_shift) begin
      sh_val <= src_a;
      sh_cnt <= shamt;
      sh_op  <= alu_control;
    end else if (state == SHIFT) begin
      sh_val <= sh_step;
      sh_cnt <= sh_cnt - SHW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_val;
      zero      <= (load_val == '0);
    end else if (accept || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_alu_unit
// Scoreboard bench for seq_alu_unit: directed cases plus random operations
// checked against an arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seq_alu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  logic rand_ready   = 1'b0;
  logic rand_bit     = 1'b1;
  logic forced_ready = 1'b1;
  assign out_ready = rand_ready ? rand_bit : forced_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  seq_alu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rand_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    int sh;
    logic [31:0] r;
    sh = int'(b[4:0]);
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd4: r = {31'd0, (a < b)};
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((c == 4'd2 || c == 4'd6 || c == 4'd7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Monitor: latency on first presentation, stability while stalled, value at handshake.
  logic        pend = 1'b0;
  logic [31:0] held = 32'd0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got result %h with no op outstanding (cycle %0d)",
                 result, cyc);
        pend = 1'b0;
      end else begin
        if (pend) chk("result_stable", result, held);
        else      chk("latency", cyc - q[0].acc, q[0].lat - 1);
        if (out_ready) begin
          mon_e = q.pop_front();
          chk("result", result, mon_e.res);
          chk("zero", {31'd0, zero}, {31'd0, mon_e.z});
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = result;
        end
      end
    end else begin
      pend = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 200 cycles");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    e.res = model_res(c, a, b);
    e.z   = (e.res == 32'd0);
    e.acc = cyc + 1;
    e.lat = model_lat(c, b);
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    src_a       = $urandom;
    src_b       = $urandom;
    alu_control = 4'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
    end
  endtask

  initial begin
    logic        seen;
    logic [31:0] a;
    logic [31:0] b;
    int          n;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    issue(4'd0, 32'h7FFF_FFFF, 32'd1);
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 32'h8000_0000, 32'd31);
    @(negedge clk);
`ifdef ALU_BARREL_SHIFT_EN
    chk("busy_during_shift", {31'd0, busy}, 32'd0);
`else
    chk("busy_during_shift", {31'd0, busy}, 32'd1);
`endif
    @(posedge clk);
    #1;
    issue(4'd2, 32'h1234_5678, 32'h0000_0020);
    wait_drain();

    // Consumer stalls five cycles, then takes the result while an XOR is handed in.
    forced_ready = 1'b0;
    issue(4'd0, 32'h0000_1111, 32'h0000_2222);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    forced_ready = 1'b1;
    issue(4'd5, 32'hA5A5_0F0F, 32'hFFFF_0000);
    wait_drain();

    // Reset pulsed in the middle of a long shift discards the operation.
    issue(4'd6, 32'hDEAD_BEEF, 32'd20);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_result", result, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_output_after_rst", {31'd0, seen}, 32'd0);
    @(posedge clk);
    #1;
    issue(4'b1111, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      issue(4'($urandom_range(0, 15)), a, b);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
